// File: rtl/sm3_pkg.sv
// ---------------------------------------------------------------------------
// sm3_pkg
//   Shared SM3 (GB/T 32905) definitions used by the message expander and the
//   compression-round engine: word type, expansion sizes, the FSM state type
//   of the streaming expander and the rotate / permutation helpers.
//   No ports (package).
// ---------------------------------------------------------------------------
package sm3_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned N_W    = 68;  // W[0..67]
    localparam int unsigned N_WP   = 64;  // W'[0..63]

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // Rotate left by a constant amount in 0..31.
    function automatic word_t rotl32(input word_t x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    // Permutation used by the compression round.
    function automatic word_t sm3_p0(input word_t x);
        return x ^ rotl32(x, 9) ^ rotl32(x, 17);
    endfunction

    // Permutation used by the message expansion.
    function automatic word_t sm3_p1(input word_t x);
        return x ^ rotl32(x, 15) ^ rotl32(x, 23);
    endfunction

endpackage

// File: rtl/sm3_w_gen.sv
// ---------------------------------------------------------------------------
// sm3_w_gen
//   Combinational single-word SM3 message expansion step:
//     W[n] = P1(W[n-16] ^ W[n-9] ^ ROTL(W[n-3],15)) ^ ROTL(W[n-13],7) ^ W[n-6]
// Ports
//   w_m16, w_m13, w_m9, w_m6, w_m3  in   word W[n-16] .. W[n-3]
//   w_new                           out  word W[n]
// ---------------------------------------------------------------------------
module sm3_w_gen
    import sm3_pkg::*;
(
    input  word_t w_m16,
    input  word_t w_m13,
    input  word_t w_m9,
    input  word_t w_m6,
    input  word_t w_m3,
    output word_t w_new
);

    word_t mix;

    assign mix   = w_m16 ^ w_m9 ^ rotl32(w_m3, 15);
    assign w_new = sm3_p1(mix) ^ rotl32(w_m13, 7) ^ w_m6;

endmodule

// File: rtl/sm3_msg_expand_stream.sv
// ---------------------------------------------------------------------------
// sm3_msg_expand_stream
//   Sequential SM3 message expander. Takes one padded 512-bit block and
//   streams W[j] and W'[j] = W[j] ^ W[j+4] for j = 0..63, LANES words per
//   beat, using a 16-word sliding window instead of a flat expander.
// Parameters
//   LANES      words per beat, 1, 2 or 4 (64/LANES beats per block)
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low
//   blk_valid  in   blk_data holds a block
//   blk_ready  out  block accepted when blk_valid & blk_ready
//   blk_data   in   512-bit block, W[0] in bits [511:480]
//   w_valid    out  beat available
//   w_ready    in   beat taken when w_valid & w_ready
//   w_data     out  lane k = W[w_idx+k]
//   wp_data    out  lane k = W'[w_idx+k]
//   w_idx      out  j of lane 0
//   w_last     out  beat carries j = 63
// ---------------------------------------------------------------------------
module sm3_msg_expand_stream
    import sm3_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [511:0]          blk_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [32*LANES-1:0]   w_data,
    output logic [32*LANES-1:0]   wp_data,
    output logic [5:0]            w_idx,
    output logic                  w_last
);

    localparam logic [5:0] J_STEP = 6'(LANES);
    localparam logic [5:0] J_LAST = 6'(64 - LANES);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_check
        $error("sm3_msg_expand_stream: LANES must be 1, 2 or 4");
    end

    state_e     state_q, state_d;
    word_t      win_q [16];
    word_t      win_d [16];
    logic [5:0] j_q, j_d;

    word_t      new_w   [LANES];
    word_t      shift_w [16];
    word_t      load_w  [16];

    // Expansion generators. Lane k produces W[j+16+k]; its W[n-3] operand
    // lies in the window for k < 3 and is lane k-3's fresh word otherwise.
    for (genvar k = 0; k < LANES; k++) begin : g_gen
        word_t w_m3;
        word_t w_new;

        if (k < 3) begin : g_win
            assign w_m3 = win_q[k+13];
        end else begin : g_chain
            assign w_m3 = g_gen[k-3].w_new;
        end

        sm3_w_gen u_w_gen (
            .w_m16 (win_q[k]),
            .w_m13 (win_q[k+3]),
            .w_m9  (win_q[k+7]),
            .w_m6  (win_q[k+10]),
            .w_m3  (w_m3),
            .w_new (w_new)
        );

        assign new_w[k] = w_new;
    end

    // Window after one beat: drop LANES oldest words, append the new ones.
    for (genvar i = 0; i < 16; i++) begin : g_shift
        if (i + LANES < 16) begin : g_keep
            assign shift_w[i] = win_q[i+LANES];
        end else begin : g_new
            assign shift_w[i] = new_w[i+LANES-16];
        end
        assign load_w[i] = blk_data[32*(15-i) +: 32];
    end

    // Output lanes straight from the window.
    for (genvar k = 0; k < LANES; k++) begin : g_out
        assign w_data[32*k +: 32]  = win_q[k];
        assign wp_data[32*k +: 32] = win_q[k] ^ win_q[k+4];
    end

    assign w_idx  = j_q;
    assign w_last = (state_q == StRun) && (j_q == J_LAST);

    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        blk_ready = 1'b0;
        w_valid   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        unique case (state_q)
            StIdle: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = load_w[i];
                    end
                    j_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                w_valid = 1'b1;
                if (w_ready) begin
                    // j wraps to 0 on the last beat, so IDLE shows w_idx = 0.
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = shift_w[i];
                    end
                    j_d = j_q + J_STEP;
                    if (w_last) begin
                        blk_ready = 1'b1;
                        if (blk_valid) begin
                            // Back-to-back block: no bubble beat.
                            for (int i = 0; i < 16; i++) begin
                                win_d[i] = load_w[i];
                            end
                            j_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            j_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sm3_msg_expand_stream.sv
// ---------------------------------------------------------------------------
// tb_sm3_msg_expand_stream
//   Scoreboard bench for the streaming SM3 expander with LANES = 1, 2 and 4
//   side by side. Each accepted block pushes its expected beats (from a flat
//   reference expansion) into a per-instance queue; a monitor compares every
//   valid beat against the queue head and pops on handshake.
// ---------------------------------------------------------------------------
module tb_sm3_msg_expand_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] BLK_REP = {16{32'h61626364}};
    localparam logic [511:0] BLK_T3  = {32'h80000000, {14{32'h00000000}}, 32'h00000200};

    typedef logic [67:0][31:0] warr_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Flat reference expansion of the whole block.
    function automatic warr_t expand(input logic [511:0] b);
        warr_t w;
        logic [31:0] t;
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 68; i++) begin
            t    = w[i-16] ^ w[i-9] ^ rl(w[i-3], 15);
            w[i] = (t ^ rl(t, 15) ^ rl(t, 23)) ^ rl(w[i-13], 7) ^ w[i-6];
        end
        return w;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L  = 1 << g;
        localparam int unsigned NB = 64 / L;
        localparam int unsigned DW = 32 * L;

        logic            rst_n, blk_valid, blk_ready, w_valid, w_ready, w_last;
        logic [511:0]    blk_data;
        logic [DW-1:0]   w_data, wp_data;
        logic [5:0]      w_idx;

        typedef struct {
            logic [DW-1:0] w;
            logic [DW-1:0] wp;
            logic [5:0]    idx;
            logic          last;
            logic          chk;
            logic [31:0]   wp63;
        } exp_t;

        exp_t q[$];

        sm3_msg_expand_stream #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .blk_valid (blk_valid),
            .blk_ready (blk_ready),
            .blk_data  (blk_data),
            .w_valid   (w_valid),
            .w_ready   (w_ready),
            .w_data    (w_data),
            .wp_data   (wp_data),
            .w_idx     (w_idx),
            .w_last    (w_last)
        );

        function automatic string nm(input string s);
            return $sformatf("L%0d %s", L, s);
        endfunction

        task automatic push_block(input logic [511:0] b, input logic chk,
                                  input logic [31:0] wp63);
            warr_t w;
            exp_t  e;
            w = expand(b);
            for (int t = 0; t < int'(NB); t++) begin
                for (int k = 0; k < int'(L); k++) begin
                    e.w[32*k +: 32]  = w[t*L+k];
                    e.wp[32*k +: 32] = w[t*L+k] ^ w[t*L+k+4];
                end
                e.idx  = 6'(t * L);
                e.last = (t == int'(NB) - 1);
                e.chk  = chk && e.last;
                e.wp63 = wp63;
                q.push_back(e);
            end
        endtask

        // Present a block; returns the number of cycles blk_ready stayed low.
        task automatic send_block(input logic [511:0] b, input logic chk,
                                  input logic [31:0] wp63, output int waits);
            bit ok;
            ok        = 1'b0;
            waits     = 0;
            blk_valid = 1'b1;
            blk_data  = b;
            for (int c = 0; c < 300 && !ok; c++) begin
                @(negedge clk);
                if (blk_ready) begin
                    push_block(b, chk, wp63);
                    ok = 1'b1;
                end else begin
                    waits++;
                end
                @(posedge clk); #1;
            end
            blk_valid = 1'b0;
            if (!ok) check(nm("accept timeout"), 128'(0), 128'(1));
        endtask

        task automatic drain(input bit rnd);
            int c;
            c = 0;
            while (q.size() != 0 && c < 1000) begin
                if (rnd) w_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                c++;
            end
            w_ready = 1'b1;
            if (q.size() != 0) check(nm("drain timeout"), 128'(q.size()), 128'(0));
            @(posedge clk); #1;
        endtask

        // Monitor / scoreboard.
        initial begin
            bit   prev_stall;
            exp_t e;
            prev_stall = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_stall = 1'b0;
                end else begin
                    if (w_valid) begin
                        if (q.size() == 0) begin
                            check(nm("spurious beat"), 128'(w_valid), 128'(0));
                        end else begin
                            e = q[0];
                            check(nm("w_data"), 128'(w_data), 128'(e.w));
                            check(nm("wp_data"), 128'(wp_data), 128'(e.wp));
                            check(nm("w_idx"), 128'(w_idx), 128'(e.idx));
                            check(nm("w_last"), 128'(w_last), 128'(e.last));
                            if (e.chk)
                                check(nm("W'63 const"), 128'(wp_data[DW-1 -: 32]),
                                      128'(e.wp63));
                            if (w_ready) void'(q.pop_front());
                        end
                    end else if (prev_stall) begin
                        check(nm("valid dropped"), 128'(w_valid), 128'(1));
                    end
                    prev_stall = w_valid && !w_ready;
                end
            end
        end

        // Stimulus.
        initial begin
            int waits;
            int c;
            rst_n     = 1'b0;
            blk_valid = 1'b0;
            blk_data  = '0;
            w_ready   = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check(nm("reset w_valid"), 128'(w_valid), 128'(0));
            check(nm("reset blk_ready"), 128'(blk_ready), 128'(1));
            check(nm("reset w_last"), 128'(w_last), 128'(0));
            check(nm("reset w_idx"), 128'(w_idx), 128'(0));
            rst_n = 1'b1;
            @(posedge clk); #1;

            // "abc" block, w_ready high.
            send_block(BLK_ABC, 1'b1, 32'h49e260d5, waits);
            check(nm("T1 W0"), 128'(w_data[31:0]), 128'(32'h61626380));
            drain(1'b0);

            // Repeated-word block.
            send_block(BLK_REP, 1'b1, 32'heda9692d, waits);
            check(nm("T2 W0"), 128'(w_data[31:0]), 128'(32'h61626364));
            drain(1'b0);

            // T3 block followed back-to-back by the abc block.
            send_block(BLK_T3, 1'b1, 32'hb863c496, waits);
            send_block(BLK_ABC, 1'b1, 32'h49e260d5, waits);
            check(nm("b2b wait cycles"), 128'(waits), 128'(NB - 1));
            check(nm("b2b no bubble"), 128'(w_valid), 128'(1));
            check(nm("b2b idx restart"), 128'(w_idx), 128'(0));
            drain(1'b0);

            // Random backpressure.
            send_block(BLK_ABC, 1'b1, 32'h49e260d5, waits);
            drain(1'b1);

            // Reset in mid-block at beat 20.
            send_block(BLK_REP, 1'b0, 32'h0, waits);
            c = 0;
            while (w_idx != 6'd20 && c < 100) begin
                @(posedge clk); #1;
                c++;
            end
            check(nm("reach beat 20"), 128'(w_idx), 128'(20));
            rst_n = 1'b0;
            q.delete();
            @(posedge clk); #1;
            check(nm("mid reset w_valid"), 128'(w_valid), 128'(0));
            check(nm("mid reset blk_ready"), 128'(blk_ready), 128'(1));
            rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            check(nm("post reset idle"), 128'(w_valid), 128'(0));
            send_block(BLK_REP, 1'b1, 32'heda9692d, waits);
            drain(1'b0);

            // blk_valid held high while busy.
            send_block(BLK_ABC, 1'b1, 32'h49e260d5, waits);
            send_block(BLK_T3, 1'b1, 32'hb863c496, waits);
            check(nm("held valid wait"), 128'(waits), 128'(NB - 1));
            drain(1'b0);

            done_cnt++;
        end
    end

    initial begin
        fork
            begin
                wait (done_cnt == 3);
            end
            begin
                #1ms;
                n_bad++;
                $display("FAIL watchdog: got timeout expected completion");
            end
        join_any
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
